usb_rx_bit_unstuffer: RTL

Receive-side counterpart of the USB transmit bit stuffer. It consumes the NRZI-decoded serial bit stream one bit per `shift_enable` strobe and removes the 0 the transmitter inserts after every six consecutive 1s. It flags a stuffing violation when a seventh consecutive 1 arrives. Surviving data bits are assembled LSB-first into bytes for the RX packet decoder. It sits between the RX NRZI decoder/timer and the RX byte/packet FSM.

---
 rtl/usb_rx_bit_unstuffer.sv | 82 ++++++++
 1 files changed

// File: rtl/usb_rx_bit_unstuffer.sv
// usb_rx_bit_unstuffer: drops USB stuffed zeros, flags a seventh consecutive 1 and assembles LSB-first bytes
module usb_rx_bit_unstuffer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       shift_enable,
  input  logic       d_orig,
  input  logic       clear,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       stuff_skip,
  output logic       stuff_err,
  output logic [7:0] rx_byte,
  output logic       byte_ready
);
  typedef enum logic [2:0] {ONES0, ONES1, ONES2, ONES3, ONES4, ONES5, ONES6, ERR} state_e;
  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d, rx_byte_q, rx_byte_d;
  logic [2:0] cnt_q, cnt_d;
  logic       bit_out_q, bit_out_d, bit_valid_q, bit_valid_d, skip_q, skip_d;
  logic       err_q, err_d, byte_ready_q, byte_ready_d;
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    rx_byte_d = rx_byte_q;
    bit_out_d = bit_out_q;
    err_d = err_q;
    bit_valid_d = 1'b0;
    skip_d = 1'b0;
    byte_ready_d = 1'b0;
    if (clear) begin
      state_d = ONES0;
      sh_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (shift_enable && state_q != ERR) begin
      if (state_q == ONES6) begin
        // a 0 here is the transmitter's stuffed bit, a 1 is a violation
        state_d = d_orig ? ERR : ONES0;
        skip_d = !d_orig;
        err_d = err_q | d_orig;
      end else begin
        state_d = d_orig ? state_e'(state_q + 3'd1) : ONES0;
        bit_out_d = d_orig;
        bit_valid_d = 1'b1;
        sh_d = {d_orig, sh_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        byte_ready_d = cnt_q == 3'd7;
        rx_byte_d = byte_ready_d ? sh_d : rx_byte_q;
      end
    end
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ONES0;
      sh_q <= '0;
      cnt_q <= '0;
      rx_byte_q <= '0;
      bit_out_q <= 1'b0;
      bit_valid_q <= 1'b0;
      skip_q <= 1'b0;
      err_q <= 1'b0;
      byte_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      rx_byte_q <= rx_byte_d;
      bit_out_q <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      skip_q <= skip_d;
      err_q <= err_d;
      byte_ready_q <= byte_ready_d;
    end
  end
  assign bit_out = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign stuff_skip = skip_q;
  assign stuff_err = err_q;
  assign rx_byte = rx_byte_q;
  assign byte_ready = byte_ready_q;
endmodule
